rf_write_arbiter: RTL and testbench

//  Shares the single architectural register-file write port between N_REQ writeback

---
 rtl/rf_write_arbiter.sv | 96 +++++++++
 tb/tb_rf_write_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares the register-file write port between N_REQ writeback sources.
// Registers the winning write as a one-hot cell enable plus a common address/data bus.
module rf_write_arbiter #(
   parameter int N_REQ    = 3,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int DATA_W   = 32,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       hold,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic [NUM_REGS-1:0]        wr_en,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic                       wr_valid,
   output logic [ID_W-1:0]            wr_id
);

   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     grant_id;
   logic [ID_W-1:0]     next_ptr;
   logic                found;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic [NUM_REGS-1:0] sel_dec;

   // Rotating priority done as two linear passes: indices at/after ptr first, then the ones before it.
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      if (!reset && !hold) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= ptr)) begin
               found    = 1'b1;
               grant_id = ID_W'(i);
            end
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (ID_W'(i) < ptr)) begin
               found    = 1'b1;
               grant_id = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = found && (grant_id == ID_W'(i));
         if (found && (grant_id == ID_W'(i))) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Register 0 and out-of-range addresses never match a decode line, so they write nothing.
   always_comb begin
      sel_dec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         sel_dec[r] = (sel_addr == ADDR_W'(r));
      end
   end

   assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr      <= '0;
         wr_en    <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_valid <= 1'b0;
         wr_id    <= '0;
      end else begin
         wr_valid <= found;
         wr_en    <= '0;
         if (found) begin
            ptr     <= next_ptr;
            wr_id   <= grant_id;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            wr_en   <= sel_dec;
         end
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a behavioural round-robin model is compared every cycle,
// and hand-computed literals pin the key scenarios.
module tb_rf_write_arbiter;

   localparam int N_REQ    = 3;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int ID_W     = 2;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    hold;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic [NUM_REGS-1:0]     wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic                    wr_valid;
   logic [ID_W-1:0]         wr_id;

   int checks   = 0;
   int failures = 0;

   // Model state: what the registered outputs must hold, plus the round-robin start point.
   int          m_ptr   = 0;
   logic [63:0] m_en    = '0;
   logic [63:0] m_addr  = '0;
   logic [63:0] m_data  = '0;
   logic        m_valid = 1'b0;
   int          m_id    = 0;
   bit          model_ok = 1'b0;

   rf_write_arbiter #(
      .N_REQ(N_REQ), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
   ) dut (
      .clk(clk), .reset(reset), .hold(hold),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_valid(wr_valid), .wr_id(wr_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // First valid requester found walking upward from ptr with modulo wrap.
   function automatic int modelGrant(input logic [N_REQ-1:0] v, input logic h, input logic r, input int p);
      if (r || h) return -1;
      for (int k = 0; k < N_REQ; k++) begin
         if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int g;
      int a;
      if (reset) begin
         m_ptr = 0; m_en = '0; m_addr = '0; m_data = '0; m_valid = 1'b0; m_id = 0;
         model_ok = 1'b1;
      end else begin
         g = modelGrant(req_valid, hold, 1'b0, m_ptr);
         if (g >= 0) begin
            a       = int'(req_addr[g*ADDR_W +: ADDR_W]);
            m_valid = 1'b1;
            m_id    = g;
            m_addr  = 64'(a);
            m_data  = 64'(req_data[g*DATA_W +: DATA_W]);
            m_en    = (a != 0 && a < NUM_REGS) ? (64'd1 << a) : 64'd0;
            m_ptr   = (g + 1) % N_REQ;
         end else begin
            m_valid = 1'b0;
            m_en    = '0;
         end
      end
   end

   always @(negedge clk) begin
      int g;
      if (model_ok) begin
         g = modelGrant(req_valid, hold, reset, m_ptr);
         checkOutput("model_req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
         checkOutput("model_wr_en",     64'(wr_en),     m_en);
         checkOutput("model_wr_valid",  64'(wr_valid),  64'(m_valid));
         checkOutput("model_wr_id",     64'(wr_id),     64'(m_id));
         checkOutput("model_wr_addr",   64'(wr_addr),   m_addr);
         checkOutput("model_wr_data",   64'(wr_data),   m_data);
      end
   end

   // Drives one cycle of inputs just after the rising edge, then returns at the falling edge.
   task automatic applyStimulus(input logic rst, input logic hld, input logic [N_REQ-1:0] v,
                                input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d0,
                                input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
      @(posedge clk);
      #1;
      reset     = rst;
      hold      = hld;
      req_valid = v;
      req_addr  = {a2, a1, a0};
      req_data  = {d2, d1, d0};
      @(negedge clk);
   endtask

   int exp_g[6] = '{0, 1, 2, 0, 1, 2};

   initial begin
      reset = 1'b1; hold = 1'b0; req_valid = 3'b111; req_addr = '0; req_data = '0;

      $display("[TB] reset with all requests valid");
      applyStimulus(1'b1, 1'b0, 3'b111, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h33);
      checkOutput("reset_ready_c1", 64'(req_ready), 64'd0);
      applyStimulus(1'b1, 1'b0, 3'b111, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h33);
      checkOutput("reset_ready_c2", 64'(req_ready), 64'd0);
      checkOutput("reset_wr_en",    64'(wr_en),     64'd0);
      applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("post_reset_wr_en",    64'(wr_en),    64'd0);
      checkOutput("post_reset_wr_valid", 64'(wr_valid), 64'd0);
      applyStimulus(1'b0, 1'b0, 3'b111, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h33);
      checkOutput("first_grant", 64'(req_ready), 64'b001);

      $display("[TB] single write from requester 1");
      applyStimulus(1'b0, 1'b0, 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0);
      checkOutput("single_ready", 64'(req_ready), 64'b010);
      applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("single_wr_en",    64'(wr_en),    64'h20);
      checkOutput("single_wr_data",  64'(wr_data),  64'hDEADBEEF);
      checkOutput("single_wr_id",    64'(wr_id),    64'd1);
      checkOutput("single_wr_valid", 64'(wr_valid), 64'd1);

      $display("[TB] x0 write from requester 2 with ptr at 2");
      applyStimulus(1'b0, 1'b0, 3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1);
      checkOutput("x0_ready", 64'(req_ready), 64'b100);
      applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("x0_wr_valid", 64'(wr_valid), 64'd1);
      checkOutput("x0_wr_en",    64'(wr_en),    64'd0);
      checkOutput("x0_wr_id",    64'(wr_id),    64'd2);

      $display("[TB] round robin with all valid");
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, 1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 32'd100, 32'd101, 32'd102);
         checkOutput("rr_ready", 64'(req_ready), 64'd1 << exp_g[c]);
         if (c > 0) begin
            checkOutput("rr_wr_id", 64'(wr_id), 64'(exp_g[c-1]));
            checkOutput("rr_wr_en", 64'(wr_en), 64'd1 << (10 + exp_g[c-1]));
         end
      end

      $display("[TB] hold with ptr at 1");
      applyStimulus(1'b0, 1'b0, 3'b001, 5'd10, 5'd11, 5'd12, 32'd100, 32'd101, 32'd102);
      checkOutput("pre_hold_ready", 64'(req_ready), 64'b001);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b1, 3'b111, 5'd10, 5'd11, 5'd12, 32'd100, 32'd101, 32'd102);
         checkOutput("hold_ready", 64'(req_ready), 64'd0);
         if (c > 0) checkOutput("hold_wr_en", 64'(wr_en), 64'd0);
      end
      applyStimulus(1'b0, 1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 32'd100, 32'd101, 32'd102);
      checkOutput("hold_release_ready", 64'(req_ready), 64'b010);

      $display("[TB] reset while a write is in flight");
      applyStimulus(1'b0, 1'b0, 3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77);
      checkOutput("midop_ready", 64'(req_ready), 64'b100);
      applyStimulus(1'b1, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      checkOutput("midop_inflight_en", 64'(wr_en), 64'h80);
      applyStimulus(1'b0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
      checkOutput("midop_cleared_en",  64'(wr_en),     64'd0);
      checkOutput("midop_ptr_zero",    64'(req_ready), 64'b001);

      applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
